kim_if_stage_p: RTL

Instruction-fetch stage of the 32-bit pipelined MIPS core. It owns the program counter, drives the byte address into the asynchronous little-endian instruction memory, and captures the returned 32-bit word into the IF/ID pipeline register. The stage honours stall and redirect (branch/jump) requests from the hazard and decode logic and inserts bubbles on redirect.

---
 rtl/kim_if_stage_p_if.sv | 40 ++++
 rtl/kim_if_stage_p.sv | 127 ++++++++++++
 2 files changed

// File: rtl/kim_if_stage_p_if.sv
// ============================================================================
// Module      : kim_if_stage_p_if
// Description : Fetch-stage bus: redirect/stall controls, instruction memory
//               port and IF/ID pipeline register outputs.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface kim_if_stage_p_if #(
  parameter int PC_WIDTH       = 32,
  parameter int MEM_ADDR_WIDTH = 6
);
  logic                      stall;
  logic                      redirect_valid;
  logic [PC_WIDTH-1:0]       redirect_target;
  logic [31:0]               instruction;
  logic [MEM_ADDR_WIDTH-1:0] r_addr_by_pc;
  logic [PC_WIDTH-1:0]       pc;
  logic [31:0]               if_id_instr;
  logic [PC_WIDTH-1:0]       if_id_pc_plus4;
  logic                      if_id_valid;
  logic                      fetch_misalign;
  logic [PC_WIDTH-1:0]       misalign_pc;

  // Fetch stage side
  modport master (
    input  stall, redirect_valid, redirect_target, instruction,
    output r_addr_by_pc, pc, if_id_instr, if_id_pc_plus4, if_id_valid,
           fetch_misalign, misalign_pc
  );

  // Hazard/decode logic and instruction memory side
  modport slave (
    output stall, redirect_valid, redirect_target, instruction,
    input  r_addr_by_pc, pc, if_id_instr, if_id_pc_plus4, if_id_valid,
           fetch_misalign, misalign_pc
  );
endinterface

`default_nettype wire

// File: rtl/kim_if_stage_p.sv
// ============================================================================
// Module      : kim_if_stage_p
// Description : MIPS instruction-fetch stage: PC, memory address, IF/ID reg.
//               Define KIM_IF_ALIGN_CHECK_EN to trap misaligned redirects.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module kim_if_stage_p #(
  parameter int                  PC_WIDTH       = 32,
  parameter int                  MEM_ADDR_WIDTH = 6,
  parameter logic [PC_WIDTH-1:0] RESET_PC       = '0
) (
  input  wire                     clk,
  input  wire                     reset,
  kim_if_stage_p_if.master        bus
);

  localparam logic [PC_WIDTH-1:0] c_pc_step   = PC_WIDTH'(4);
  localparam logic [PC_WIDTH-1:0] c_align_msk = ~PC_WIDTH'(3);

  typedef enum logic [0:0] {FETCH = 1'b0, HALT = 1'b1} state_t;

  state_t              r_state, w_state_next;
  logic [PC_WIDTH-1:0] r_pc, w_pc_next;
  logic [31:0]         r_instr, w_instr_next;
  logic [PC_WIDTH-1:0] r_pc_plus4, w_pc_plus4_next;
  logic                r_valid, w_valid_next;
  logic [PC_WIDTH-1:0] w_pc_plus4;

`ifdef KIM_IF_ALIGN_CHECK_EN
  logic                r_misalign, w_misalign_next;
  logic [PC_WIDTH-1:0] r_misalign_pc, w_misalign_pc_next;
`endif

  assign w_pc_plus4 = r_pc + c_pc_step;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_instr    <= 32'h0000_0000;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_instr    <= w_instr_next;
      r_pc_plus4 <= w_pc_plus4_next;
      r_valid    <= w_valid_next;
    end
  end

`ifdef KIM_IF_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_misalign    <= 1'b0;
      r_misalign_pc <= '0;
    end else begin
      r_misalign    <= w_misalign_next;
      r_misalign_pc <= w_misalign_pc_next;
    end
  end
`endif

  // Priority inside FETCH: redirect > stall > sequential advance
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_instr_next    = r_instr;
    w_pc_plus4_next = r_pc_plus4;
    w_valid_next    = r_valid;
`ifdef KIM_IF_ALIGN_CHECK_EN
    w_misalign_next    = r_misalign;
    w_misalign_pc_next = r_misalign_pc;
`endif
    case (r_state)
      FETCH: begin
        if (bus.redirect_valid) begin
          w_instr_next    = 32'h0000_0000;
          w_pc_plus4_next = '0;
          w_valid_next    = 1'b0;
`ifdef KIM_IF_ALIGN_CHECK_EN
          if (bus.redirect_target[1:0] != 2'b00) begin
            w_misalign_next    = 1'b1;
            w_misalign_pc_next = bus.redirect_target;
            w_state_next       = HALT;
          end else begin
            w_pc_next = bus.redirect_target;
          end
`else
          w_pc_next = bus.redirect_target & c_align_msk;
`endif
        end else if (!bus.stall) begin
          w_pc_next       = w_pc_plus4;
          w_instr_next    = bus.instruction;
          w_pc_plus4_next = w_pc_plus4;
          w_valid_next    = 1'b1;
        end
      end
      HALT: begin
        w_instr_next    = 32'h0000_0000;
        w_pc_plus4_next = '0;
        w_valid_next    = 1'b0;
      end
      default: begin
        w_state_next = FETCH;
      end
    endcase
  end

  assign bus.r_addr_by_pc   = r_pc[MEM_ADDR_WIDTH-1:0];
  assign bus.pc             = r_pc;
  assign bus.if_id_instr    = r_instr;
  assign bus.if_id_pc_plus4 = r_pc_plus4;
  assign bus.if_id_valid    = r_valid;
`ifdef KIM_IF_ALIGN_CHECK_EN
  assign bus.fetch_misalign = r_misalign;
  assign bus.misalign_pc    = r_misalign_pc;
`else
  assign bus.fetch_misalign = 1'b0;
  assign bus.misalign_pc    = '0;
`endif

endmodule

`default_nettype wire
